// File: rtl/xor_share_arbiter.sv
// Purpose: round-robin arbiter sharing one N-bit XOR datapath among NREQ requesters.
// Latency: 1 cycle from request handshake to out_valid; sustains 1 result/cycle.
// Backpressure: out_ready=0 with a held result freezes all state; req_ready drops to zero.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   enable               gates new grants; a held result still drains
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_i0/req_i1        flattened operands, requester k at [k*N +: N]
//   out_valid/out_ready  result handshake; out = i0 ^ i1, out_id = winner index
// Optional build macro XOR_SHARE_GRANT_CNT_EN adds cnt_clr and grant_cnt
// (16-bit saturating handshake counters per requester, requester k at [k*16 +: 16]).
module xor_share_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*N-1:0]  req_i0,
  input  logic [NREQ*N-1:0]  req_i1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out,
  output logic [IDW-1:0]     out_id
`ifdef XOR_SHARE_GRANT_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  localparam int IDW1 = IDW + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_out;
  logic [IDW-1:0]   r_out_id;
  logic [IDW-1:0]   r_rr_ptr;

  logic             w_load;
  logic             w_hs;
  logic             w_found;
  logic [NREQ-1:0]  w_grant;
  logic [NREQ-1:0]  w_ready;
  logic [IDW-1:0]   w_gnt_idx;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [IDW:0]     w_scan;
  logic [N-1:0]     w_xor;

  // Rotating priority scan: offset i from rr_ptr, wrapped modulo NREQ.
  // The extra bit in w_scan keeps the wrap correct for non power-of-two NREQ.
  always_comb begin
    w_grant   = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_scan = {1'b0, r_rr_ptr} + IDW1'(i);
      if (w_scan >= IDW1'(NREQ)) begin
        w_scan = w_scan - IDW1'(NREQ);
      end
      if (!w_found && req_valid[w_scan[IDW-1:0]]) begin
        w_found                    = 1'b1;
        w_grant[w_scan[IDW-1:0]]   = 1'b1;
        w_gnt_idx                  = w_scan[IDW-1:0];
      end
    end
  end

  // Accepting while FULL is allowed when the held result leaves this cycle.
  assign w_load    = (r_state == ST_EMPTY) | out_ready;
  assign w_ready   = w_grant & {NREQ{w_load & enable}};
  assign w_hs      = |w_ready;
  assign req_ready = w_ready;

  assign w_xor     = req_i0[int'(w_gnt_idx) * N +: N] ^ req_i1[int'(w_gnt_idx) * N +: N];
  assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = w_hs ? ST_FULL : ST_EMPTY;
    end
  end

  // Result, ID and pointer only move on a handshake; a stall or enable=0 holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_out_id <= '0;
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_out    <= w_xor;
      r_out_id <= w_gnt_idx;
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out       = r_out;
  assign out_id    = r_out_id;

`ifdef XOR_SHARE_GRANT_CNT_EN
  logic [15:0] r_cnt [NREQ];

  // Clear has priority over a same-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (cnt_clr) begin
      for (int k = 0; k < NREQ; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (w_ready[k] && req_valid[k] && (r_cnt[k] != 16'hFFFF)) begin
          r_cnt[k] <= r_cnt[k] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign grant_cnt[g*16 +: 16] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
module tb_xor_share_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              out_ready = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_i0 = '0;
  logic [NREQ*N-1:0] req_i1 = '0;
  logic              out_valid;
  logic [N-1:0]      out;
  logic [IDW-1:0]    out_id;
`ifdef XOR_SHARE_GRANT_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [NREQ*16-1:0] grant_cnt;
`endif

  xor_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_i0    (req_i0),
    .req_i1    (req_i1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_id    (out_id)
`ifdef XOR_SHARE_GRANT_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Fixed operands used by the directed vectors.
  logic [N-1:0] op_a [NREQ];
  logic [N-1:0] op_b [NREQ];

  task automatic load_fixed_ops();
    op_a[0] = 32'h0000_00FF; op_b[0] = 32'h0000_0F0F;  // -> 00000FF0
    op_a[1] = 32'h1234_5678; op_b[1] = 32'hFFFF_0000;  // -> EDCB5678
    op_a[2] = 32'h5F09_F0A3; op_b[2] = 32'h900E_A593;  // -> CF075530
    op_a[3] = 32'hDEAD_BEEF; op_b[3] = 32'h0F0F_0F0F;  // -> D1A2B1E0
    for (int k = 0; k < NREQ; k++) begin
      req_i0[k*N +: N] = op_a[k];
      req_i1[k*N +: N] = op_b[k];
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    enable    = 1'b0;
    out_ready = 1'b0;
`ifdef XOR_SHARE_GRANT_CNT_EN
    cnt_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset out", 64'(out), 64'(0));
    chk("reset out_id", 64'(out_id), 64'(0));
    chk("reset req_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0] vld;
    logic            en;
    logic            ordy;
    logic [NREQ-1:0] x_rdy;
    logic            x_ov;
    logic [N-1:0]    x_out;
    logic [IDW-1:0]  x_id;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [NREQ-1:0] vld, input logic en, input logic ordy,
                     input logic [NREQ-1:0] x_rdy, input logic x_ov,
                     input logic [N-1:0] x_out, input logic [IDW-1:0] x_id);
    vec_t v;
    v.vld = vld; v.en = en; v.ordy = ordy;
    v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_out = x_out; v.x_id = x_id;
    tbl.push_back(v);
  endtask

  // Behavioural reference for the random phase.
  int           m_ptr;
  bit           m_full;
  logic [N-1:0] m_out;
  int           m_id;
  int           m_cnt [NREQ];
  bit           pend [NREQ];
  logic [N-1:0] ra [NREQ];
  logic [N-1:0] rb [NREQ];

  initial begin
    load_fixed_ops();
    do_reset();

    // Round-robin from reset, then backpressure, enable gating, single request.
    //   vld      en    ordy  x_rdy    x_ov  x_out          x_id
    add(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 32'h0,         2'd0);
    add(4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h00000FF0, 2'd0);
    add(4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 32'hEDCB5678, 2'd1);
    add(4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 32'hCF075530, 2'd2);
    add(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 32'hD1A2B1E0, 2'd3);
    add(4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h00000FF0, 2'd0);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 32'hEDCB5678, 2'd1);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,         2'd0);
    add(4'b0011, 1'b1, 1'b0, 4'b0001, 1'b0, 32'h0,         2'd0);
    add(4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h00000FF0, 2'd0);
    add(4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h00000FF0, 2'd0);
    add(4'b0011, 1'b1, 1'b0, 4'b0000, 1'b1, 32'h00000FF0, 2'd0);
    add(4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h00000FF0, 2'd0);
    add(4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 32'hEDCB5678, 2'd1);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 32'h00000FF0, 2'd0);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,         2'd0);
    add(4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,         2'd0);
    add(4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,         2'd0);
    add(4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0, 32'h0,         2'd0);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 32'hD1A2B1E0, 2'd3);
    add(4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 32'h0,         2'd0);
    add(4'b1000, 1'b0, 1'b0, 4'b0000, 1'b1, 32'hD1A2B1E0, 2'd3);
    add(4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'hD1A2B1E0, 2'd3);
    add(4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,         2'd0);
    add(4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0, 32'h0,         2'd0);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 32'hD1A2B1E0, 2'd3);
    add(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h0,         2'd0);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 32'hCF075530, 2'd2);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,         2'd0);

    foreach (tbl[i]) begin
      req_valid = tbl[i].vld;
      enable    = tbl[i].en;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'(tbl[i].x_rdy));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].x_ov));
      if (tbl[i].x_ov) begin
        chk($sformatf("vec%0d out", i), 64'(out), 64'(tbl[i].x_out));
        chk($sformatf("vec%0d out_id", i), 64'(out_id), 64'(tbl[i].x_id));
      end
      @(posedge clk);
      #1;
    end

    // Reset while FULL with out_id=1, then first grant restarts from index 0.
    do_reset();
    req_valid = 4'b0010; enable = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("midrst full valid", 64'(out_valid), 64'(1));
    chk("midrst full id", 64'(out_id), 64'(1));
    chk("midrst full out", 64'(out), 64'(32'hEDCB5678));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst async valid", 64'(out_valid), 64'(0));
    chk("midrst async out", 64'(out), 64'(0));
    chk("midrst async id", 64'(out_id), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1010; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst first grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("midrst post valid", 64'(out_valid), 64'(1));
    chk("midrst post id", 64'(out_id), 64'(1));
    @(posedge clk); #1;

`ifdef XOR_SHARE_GRANT_CNT_EN
    // Five grants to requester 1, then a clear that coincides with a handshake.
    do_reset();
    enable = 1'b1; out_ready = 1'b1; req_valid = 4'b0010;
    repeat (5) begin
      @(posedge clk); #1;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    chk("cnt req1 after 5", 64'(grant_cnt[31:16]), 64'(5));
    chk("cnt others after 5", 64'({grant_cnt[63:32], grant_cnt[15:0]}), 64'(0));
    @(posedge clk); #1;
    cnt_clr = 1'b1; req_valid = 4'b0010;
    @(posedge clk); #1;
    cnt_clr = 1'b0; req_valid = 4'b0000;
    @(negedge clk);
    chk("cnt after clr", 64'(grant_cnt), 64'(0));
    @(posedge clk); #1;
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_full = 1'b0; m_out = '0; m_id = 0;
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b0; m_cnt[k] = 0; ra[k] = '0; rb[k] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int  g;
      int  best;
      bit  load;
      bit  hs;
      bit  clr;
      logic [NREQ-1:0] x_rdy;
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
          pend[k] = 1'b1;
          ra[k] = $urandom;
          rb[k] = $urandom;
        end
        req_valid[k]     = pend[k];
        req_i0[k*N +: N] = ra[k];
        req_i1[k*N +: N] = rb[k];
      end
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 49) == 0);
`ifdef XOR_SHARE_GRANT_CNT_EN
      cnt_clr   = clr;
`endif
      // Winner: the pending requester at the smallest rotated distance from the pointer.
      g = -1; best = NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (pend[k] && (((k - m_ptr + NREQ) % NREQ) < best)) begin
          best = (k - m_ptr + NREQ) % NREQ;
          g = k;
        end
      end
      load  = !m_full || out_ready;
      hs    = load && enable && (g >= 0);
      x_rdy = '0;
      if (hs) x_rdy[g] = 1'b1;

      @(negedge clk);
      chk($sformatf("rnd%0d req_ready", cyc), 64'(req_ready), 64'(x_rdy));
      chk($sformatf("rnd%0d out_valid", cyc), 64'(out_valid), 64'(m_full));
      if (m_full) begin
        chk($sformatf("rnd%0d out", cyc), 64'(out), 64'(m_out));
        chk($sformatf("rnd%0d out_id", cyc), 64'(out_id), 64'(m_id));
      end
`ifdef XOR_SHARE_GRANT_CNT_EN
      for (int k = 0; k < NREQ; k++) begin
        chk($sformatf("rnd%0d cnt%0d", cyc, k), 64'(grant_cnt[k*16 +: 16]), 64'(m_cnt[k]));
      end
`endif

      @(posedge clk);
      if (load) begin
        if (hs) begin
          m_full  = 1'b1;
          m_out   = ra[g] ^ rb[g];
          m_id    = g;
          m_ptr   = (g + 1) % NREQ;
          pend[g] = 1'b0;
        end else begin
          m_full = 1'b0;
        end
      end
      if (clr) begin
        for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
      end else if (hs && (m_cnt[g] < 65535)) begin
        m_cnt[g] = m_cnt[g] + 1;
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Shares a single N-bit bitwise XOR datapath among NREQ requesters, using round-robin arbitration.
- Each requester presents an operand pair with a valid/ready handshake. The winner's result, i0 ^ i1, is registered with the winner's ID and held on a ready/valid output port.
- Sits between the client blocks and the downstream consumer. It is the only sequencer of the XOR unit.

Parameters:
- N, 32, operand and result width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  arbitration enable. Low means no new grants; the held output still drains.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept (one-hot or zero).
- req_i0  input  NREQ*N  flattened operand 0. Requester k occupies bits [k*N +: N].
- req_i1  input  NREQ*N  flattened operand 1, same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out  output  N  registered result i0 ^ i1 of the granted requester.
- out_id  output  IDW  index of the requester that produced out.

Behaviour:
- Reset (async assert, sync deassert by system): out_valid=0, out=0, out_id=0, rr_ptr=0. State goes to EMPTY.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; out and out_id are stable until out_valid & out_ready.
- load = (state==EMPTY) | out_ready. This allows accept-and-drain in the same cycle.
- Grant search (combinational):
  - Scan req_valid starting at index rr_ptr, ascending, wrapping past NREQ-1 to 0.
  - The first set bit wins. grant is one-hot; it is zero if no request is valid.
- req_ready = grant & {NREQ{load & enable}}.
  - req_ready depends combinationally on req_valid.
  - Requesters must not make req_valid depend on req_ready.
- Handshake k = req_valid[k] & req_ready[k]. On handshake, at the next rising edge:
  - out <= req_i0[k] ^ req_i1[k].
  - out_id <= k.
  - state <= FULL.
  - rr_ptr <= (k+1) mod NREQ.
- If load is 1 and no handshake occurs: state <= EMPTY. out and out_id keep their last values; they are don't-care while out_valid=0.
- If load is 0: all registers hold.
- Latency and throughput:
  - Handshake to out_valid: exactly 1 cycle.
  - Sustained throughput: 1 result per cycle while out_ready=1.
- Fairness: a continuously asserting requester is granted at least once every NREQ accepted transactions.
- rr_ptr advances only on a handshake. Stalls and enable=0 do not move it.
- Requester rules:
  - req_valid, once asserted, must stay asserted with stable operands until that requester's handshake.
  - The arbiter never drops an accepted request.
- enable deasserted mid-stream: a result already in FULL still drains normally. No new grant is issued until enable=1.
- Reset mid-operation: the held result is discarded. No partial output is produced. rr_ptr returns to 0.
- XOR is pure bitwise over N bits: no carry, no width growth.

Optional Feature:
- Macro XOR_SHARE_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, width NREQ*16; requester k occupies bits [k*16 +: 16].
  - Each counter increments on that requester's handshake and saturates at 16'hFFFF.
  - Counters reset to 0 on rst_n low.
  - Add input cnt_clr (1 bit), which synchronously zeroes all counters. If cnt_clr coincides with a handshake, the clear wins.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Single request:
  - Stimulus: requester 2 valid with i0=32'h5F09F0A3, i1=32'h900EA593; out_ready=1.
  - Response: req_ready[2]=1 in the same cycle. Next cycle out_valid=1, out=32'hCF075530, out_id=2.
- Round-robin fairness:
  - Stimulus: all 4 requesters held valid; out_ready=1 from reset.
  - Response: out_id sequence is 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while requesters 0 and 1 are valid.
  - Response: exactly one result is captured and out is stable for 3 cycles. req_ready is all zero during the stall. rr_ptr is unchanged until the next handshake.
- Enable gating:
  - Stimulus: enable=0 with requester 3 valid.
  - Response: no grant. A held result drains on out_ready=1. After enable=1, requester 3 is granted within 1 cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while FULL with out_id=1.
  - Response: out_valid=0, out=0 and out_id=0 immediately. After release, the first grant goes to the lowest valid index starting from 0.
- XOR_SHARE_GRANT_CNT_EN build:
  - Stimulus: 5 grants to requester 1, then pulse cnt_clr.
  - Response: grant_cnt[31:16]=5, then 0 for all counters on the cycle after cnt_clr.
